// File: rtl/lcd_frame_refresh.sv
// lcd_frame_refresh: ROWS x COLS character buffer, pushed to an HD44780 over the
// 8-bit parallel bus after a one-time init and again whenever the buffer changes.
module lcd_frame_refresh #(
    parameter int unsigned ROWS        = 4,
    parameter int unsigned COLS        = 20,
    parameter int unsigned POWERUP_CYC = 2_500_000,
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned E_HIGH_CYC  = 25,
    parameter int unsigned CMD_CYC     = 2_500,
    parameter int unsigned LONG_CYC    = 100_000,
    // One spare address code so power-of-two sizes still have out-of-range addresses.
    localparam int unsigned NCHR       = ROWS * COLS,
    localparam int unsigned AW         = $clog2(NCHR + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic          lcd_e,
    output logic [7:0]    lcd_data,
    output logic          init_done,
    output logic          frame_done
);

    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned MAX_A = (POWERUP_CYC > LONG_CYC) ? POWERUP_CYC : LONG_CYC;
    localparam int unsigned MAX_B = (CMD_CYC > E_HIGH_CYC) ? CMD_CYC : E_HIGH_CYC;
    localparam int unsigned MAX_C = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_POWERUP,
        S_INIT,
        S_IDLE,
        S_ADDR,
        S_CHAR
    } state_e;

    typedef enum logic [1:0] {
        B_IDLE,
        B_SETUP,
        B_STROBE,
        B_HOLD
    } bus_e;

    state_e           state_q, state_d;
    bus_e             bus_q, bus_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       step_q, step_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic             dirty_q, dirty_d;
    logic             long_q, long_d;
    logic             rs_q, rs_d;
    logic             e_q, e_d;
    logic [7:0]       data_q, data_d;
    logic             init_done_q, init_done_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0]       buf_q [NCHR];
    logic [7:0]       buf_d [NCHR];

    logic             wr_ok_c;
    logic             bus_done_c;
    logic [CNT_W-1:0] wait_c;
    logic             launch_c;
    logic             l_rs_c;
    logic             l_long_c;
    logic [7:0]       l_byte_c;
    logic [AW-1:0]    idx_c;
    logic [7:0]       ch_c;

    function automatic logic [7:0] init_byte(input logic [2:0] s);
        case (s)
            3'd0, 3'd1, 3'd2: init_byte = 8'h30;
            3'd3:             init_byte = 8'h38;
            3'd4:             init_byte = 8'h08;
            3'd5:             init_byte = 8'h01;
            3'd6:             init_byte = 8'h06;
            default:          init_byte = 8'h0C;
        endcase
    endfunction

    function automatic logic init_long(input logic [2:0] s);
        init_long = (s <= 3'd2) || (s == 3'd5);
    endfunction

    // HD44780 DDRAM start address of each row in 4-line mapping.
    function automatic logic [7:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    row_base = 8'h00;
            2'd1:    row_base = 8'h40;
            2'd2:    row_base = 8'(COLS);
            default: row_base = 8'h40 + 8'(COLS);
        endcase
    endfunction

    assign wr_ok_c    = wr_en && (wr_addr < AW'(NCHR));
    assign wait_c     = long_q ? CNT_W'(LONG_CYC - 1) : CNT_W'(CMD_CYC - 1);
    assign bus_done_c = (bus_q == B_HOLD) && (cnt_q == wait_c);

    // Frame buffer write port; out-of-range addresses fall through untouched.
    always_comb begin
        buf_d = buf_q;
        if (wr_ok_c) begin
            for (int i = 0; i < int'(NCHR); i++) begin
                if (wr_addr == AW'(i)) buf_d[i] = wr_data;
            end
        end
    end

    // Main sequencer: next state, dirty tracking and the byte to launch on a transition.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        row_d        = row_q;
        col_d        = col_q;
        dirty_d      = dirty_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        launch_c     = 1'b0;
        l_rs_c       = 1'b0;
        l_long_c     = 1'b0;
        l_byte_c     = 8'h00;
        idx_c        = '0;
        ch_c         = 8'h20;

        case (state_q)
            S_POWERUP: begin
                if (cnt_q == CNT_W'(POWERUP_CYC - 1)) begin
                    state_d  = S_INIT;
                    step_d   = 3'd0;
                    launch_c = 1'b1;
                end
            end
            S_INIT: begin
                if (bus_done_c) begin
                    if (step_q == 3'd7) begin
                        state_d     = S_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        step_d   = step_q + 3'd1;
                        launch_c = 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (dirty_q) begin
                    dirty_d  = 1'b0;
                    state_d  = S_ADDR;
                    row_d    = '0;
                    launch_c = 1'b1;
                end
            end
            S_ADDR: begin
                if (bus_done_c) begin
                    state_d  = S_CHAR;
                    col_d    = '0;
                    launch_c = 1'b1;
                end
            end
            S_CHAR: begin
                if (bus_done_c) begin
                    if (col_q == CW'(COLS - 1)) begin
                        if (row_q == RW'(ROWS - 1)) begin
                            state_d      = S_IDLE;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d  = S_ADDR;
                            row_d    = row_q + RW'(1);
                            launch_c = 1'b1;
                        end
                    end else begin
                        col_d    = col_q + CW'(1);
                        launch_c = 1'b1;
                    end
                end
            end
            default: state_d = S_POWERUP;
        endcase

        // A write in the same cycle as the dirty clear must not be lost.
        if (wr_ok_c) dirty_d = 1'b1;

        idx_c = AW'(row_d) * AW'(COLS) + AW'(col_d);
        for (int i = 0; i < int'(NCHR); i++) begin
            if (idx_c == AW'(i)) ch_c = buf_q[i];
        end

        case (state_d)
            S_INIT: begin
                l_byte_c = init_byte(step_d);
                l_long_c = init_long(step_d);
            end
            S_ADDR: l_byte_c = 8'h80 | row_base(2'(row_d));
            S_CHAR: begin
                l_byte_c = ch_c;
                l_rs_c   = 1'b1;
            end
            default: l_byte_c = 8'h00;
        endcase
    end

    // Bus cycle: SETUP (E low) -> STROBE (E high) -> HOLD (E low); rs/data only change on launch.
    always_comb begin
        bus_d  = bus_q;
        cnt_d  = cnt_q;
        rs_d   = rs_q;
        data_d = data_q;
        e_d    = e_q;
        long_d = long_q;

        case (bus_q)
            B_IDLE: begin
                if (state_q == S_POWERUP) cnt_d = cnt_q + CNT_W'(1);
            end
            B_SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    bus_d = B_STROBE;
                    cnt_d = '0;
                    e_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            B_STROBE: begin
                if (cnt_q == CNT_W'(E_HIGH_CYC - 1)) begin
                    bus_d = B_HOLD;
                    cnt_d = '0;
                    e_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            B_HOLD: begin
                if (bus_done_c) begin
                    bus_d = B_IDLE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: bus_d = B_IDLE;
        endcase

        if (launch_c) begin
            bus_d  = B_SETUP;
            cnt_d  = '0;
            e_d    = 1'b0;
            rs_d   = l_rs_c;
            data_d = l_byte_c;
            long_d = l_long_c;
        end
    end

    // State, counters and registered pin drivers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_POWERUP;
            bus_q        <= B_IDLE;
            cnt_q        <= '0;
            step_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            dirty_q      <= 1'b1;
            long_q       <= 1'b0;
            rs_q         <= 1'b0;
            e_q          <= 1'b0;
            data_q       <= 8'h00;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_q        <= bus_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            row_q        <= row_d;
            col_q        <= col_d;
            dirty_q      <= dirty_d;
            long_q       <= long_d;
            rs_q         <= rs_d;
            e_q          <= e_d;
            data_q       <= data_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Frame buffer storage, cleared to spaces on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NCHR); i++) buf_q[i] <= 8'h20;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_e      = e_q;
    assign lcd_data   = data_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_refresh.sv
// Directed bench for lcd_frame_refresh with reduced timing parameters.
module tb_lcd_frame_refresh;

    localparam int unsigned ROWS = 2;
    localparam int unsigned COLS = 4;
    localparam int unsigned AW   = $clog2(ROWS * COLS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = 8'h00;
    logic          lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
    logic [7:0]    lcd_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] mon_q [$];
    int         fd_cnt = 0;
    int         e_samples = 0;
    logic       prev_e = 1'b0;
    logic [8:0] prev_bus = 9'h000;
    int         stable = 0;
    int         ehi = 0;

    lcd_frame_refresh #(
        .ROWS(ROWS), .COLS(COLS), .POWERUP_CYC(20), .SETUP_CYC(2),
        .E_HIGH_CYC(3), .CMD_CYC(5), .LONG_CYC(10)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
        .init_done(init_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Bus monitor: records bytes at E falling and checks setup/strobe timing.
    always @(negedge clk) begin
        if (rst) begin
            prev_e   = 1'b0;
            prev_bus = {lcd_rs, lcd_data};
            stable   = 0;
            ehi      = 0;
        end else begin
            if ({lcd_rs, lcd_data} !== prev_bus) stable = 0;
            else stable++;
            if (lcd_e || prev_e) begin
                n_cmp++;
                if ({lcd_rs, lcd_data} !== prev_bus) begin
                    n_bad++;
                    $display("FAIL bus_stable_e_high: rs/data %h changed from %h while E active", {lcd_rs, lcd_data}, prev_bus);
                end
            end
            if (lcd_e) begin
                e_samples++;
                ehi++;
            end
            if (lcd_e && !prev_e) begin
                n_cmp++;
                if (stable < 2) begin
                    n_bad++;
                    $display("FAIL setup_time: stable %0d cycles before E rise, need >= 2", stable);
                end
            end
            if (!lcd_e && prev_e) begin
                n_cmp++;
                if (ehi != 3) begin
                    n_bad++;
                    $display("FAIL e_high_width: got %0d cycles, expected 3", ehi);
                end
                ehi = 0;
                mon_q.push_back({lcd_rs, lcd_data});
            end
            if (frame_done) fd_cnt++;
            prev_e   = lcd_e;
            prev_bus = {lcd_rs, lcd_data};
        end
    end

    task automatic write_byte(input logic [AW-1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (lcd_e !== 1'b0)      begin n_bad++; $display("FAIL reset_e: got %b expected 0", lcd_e); end
        n_cmp++; if (lcd_rs !== 1'b0)     begin n_bad++; $display("FAIL reset_rs: got %b expected 0", lcd_rs); end
        n_cmp++; if (lcd_rw !== 1'b0)     begin n_bad++; $display("FAIL reset_rw: got %b expected 0", lcd_rw); end
        n_cmp++; if (lcd_data !== 8'h00)  begin n_bad++; $display("FAIL reset_data: got %h expected 00", lcd_data); end
        n_cmp++; if (init_done !== 1'b0)  begin n_bad++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    endtask

    // Releases reset and checks power-up delay, init commands and the blank frame.
    task automatic test_init();
        logic [8:0] exp [18];
        int cyc;
        bit seen;
        int fd_base;
        exp = '{9'h030, 9'h030, 9'h030, 9'h038, 9'h008, 9'h001, 9'h006, 9'h00C,
                9'h080, 9'h120, 9'h120, 9'h120, 9'h120,
                9'h0C0, 9'h120, 9'h120, 9'h120, 9'h120};
        mon_q.delete();
        fd_base = fd_cnt;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk); #1;
            cyc++;
            if (lcd_e) seen = 1'b1;
        end
        n_cmp++;
        if (cyc != 22) begin n_bad++; $display("FAIL first_e_rise: got cycle %0d expected 22", cyc); end

        for (int k = 0; k < 400 && mon_q.size() < 8; k++) begin @(negedge clk); #1; end
        n_cmp++;
        if (mon_q.size() < 8) begin n_bad++; $display("FAIL init_timeout: got %0d bytes expected 8", mon_q.size()); end
        n_cmp++;
        if (init_done !== 1'b0) begin n_bad++; $display("FAIL init_done_early: got %b expected 0", init_done); end
        cyc = 0;
        for (int k = 0; k < 50 && !init_done; k++) begin @(negedge clk); #1; cyc++; end
        n_cmp++;
        if (cyc != 5) begin n_bad++; $display("FAIL init_done_delay: got %0d cycles expected 5", cyc); end

        for (int k = 0; k < 400 && mon_q.size() < 18; k++) begin @(negedge clk); #1; end
        n_cmp++;
        if (mon_q.size() < 18) begin n_bad++; $display("FAIL blank_frame_timeout: got %0d bytes expected 18", mon_q.size()); end
        for (int i = 0; i < 18; i++) begin
            if (i < mon_q.size()) begin
                n_cmp++;
                if (mon_q[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL init_byte[%0d]: got %h expected %h", i, mon_q[i], exp[i]);
                end
            end
        end
        repeat (40) @(negedge clk);
        #1;
        n_cmp++;
        if (mon_q.size() != 18) begin n_bad++; $display("FAIL init_bus_idle: got %0d bytes expected 18", mon_q.size()); end
        n_cmp++;
        if (fd_cnt - fd_base != 1) begin n_bad++; $display("FAIL init_frame_done: got %0d pulses expected 1", fd_cnt - fd_base); end
        n_cmp++;
        if (init_done !== 1'b1) begin n_bad++; $display("FAIL init_done_hold: got %b expected 1", init_done); end
    endtask

    task automatic test_single_write();
        logic [8:0] exp [10];
        int fd_base;
        exp = '{9'h080, 9'h120, 9'h120, 9'h120, 9'h120, 9'h0C0, 9'h120, 9'h141, 9'h120, 9'h120};
        mon_q.delete();
        fd_base = fd_cnt;
        write_byte(AW'(5), 8'h41);
        for (int k = 0; k < 400 && mon_q.size() < 10; k++) begin @(negedge clk); #1; end
        n_cmp++;
        if (mon_q.size() < 10) begin n_bad++; $display("FAIL single_timeout: got %0d bytes expected 10", mon_q.size()); end
        for (int i = 0; i < 10; i++) begin
            if (i < mon_q.size()) begin
                n_cmp++;
                if (mon_q[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL single_byte[%0d]: got %h expected %h", i, mon_q[i], exp[i]);
                end
            end
        end
        repeat (40) @(negedge clk);
        #1;
        n_cmp++;
        if (mon_q.size() != 10) begin n_bad++; $display("FAIL single_extra: got %0d bytes expected 10", mon_q.size()); end
        n_cmp++;
        if (fd_cnt - fd_base != 1) begin n_bad++; $display("FAIL single_frame_done: got %0d pulses expected 1", fd_cnt - fd_base); end
    endtask

    task automatic test_mid_frame_write();
        logic [8:0] exp [20];
        int fd_base;
        bit seen;
        exp = '{9'h080, 9'h120, 9'h120, 9'h120, 9'h120, 9'h0C0, 9'h120, 9'h120, 9'h120, 9'h120,
                9'h080, 9'h142, 9'h120, 9'h120, 9'h120, 9'h0C0, 9'h120, 9'h120, 9'h120, 9'h120};
        mon_q.delete();
        fd_base = fd_cnt;
        write_byte(AW'(5), 8'h20);
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk); #1;
            if (lcd_e && !lcd_rs && lcd_data == 8'hC0) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL mid_c0_timeout: got no C0 strobe expected one"); end
        write_byte(AW'(0), 8'h42);
        for (int k = 0; k < 500 && mon_q.size() < 20; k++) begin @(negedge clk); #1; end
        n_cmp++;
        if (mon_q.size() < 20) begin n_bad++; $display("FAIL mid_timeout: got %0d bytes expected 20", mon_q.size()); end
        for (int i = 0; i < 20; i++) begin
            if (i < mon_q.size()) begin
                n_cmp++;
                if (mon_q[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL mid_byte[%0d]: got %h expected %h", i, mon_q[i], exp[i]);
                end
            end
        end
        repeat (40) @(negedge clk);
        #1;
        n_cmp++;
        if (mon_q.size() != 20) begin n_bad++; $display("FAIL mid_extra: got %0d bytes expected 20", mon_q.size()); end
        n_cmp++;
        if (fd_cnt - fd_base != 2) begin n_bad++; $display("FAIL mid_frame_done: got %0d pulses expected 2", fd_cnt - fd_base); end
    endtask

    task automatic test_out_of_range();
        logic [8:0] exp [10];
        int e_base;
        exp = '{9'h080, 9'h142, 9'h120, 9'h120, 9'h120, 9'h0C0, 9'h120, 9'h120, 9'h120, 9'h120};
        mon_q.delete();
        e_base = e_samples;
        write_byte(AW'(8), 8'h55);
        repeat (200) @(negedge clk);
        #1;
        n_cmp++;
        if (e_samples != e_base) begin n_bad++; $display("FAIL oor_e_activity: got %0d E-high cycles expected 0", e_samples - e_base); end
        n_cmp++;
        if (mon_q.size() != 0) begin n_bad++; $display("FAIL oor_bytes: got %0d bytes expected 0", mon_q.size()); end
        // Rewrite a space in place to force a frame that reveals the buffer contents.
        write_byte(AW'(7), 8'h20);
        for (int k = 0; k < 400 && mon_q.size() < 10; k++) begin @(negedge clk); #1; end
        n_cmp++;
        if (mon_q.size() < 10) begin n_bad++; $display("FAIL oor_frame_timeout: got %0d bytes expected 10", mon_q.size()); end
        for (int i = 0; i < 10; i++) begin
            if (i < mon_q.size()) begin
                n_cmp++;
                if (mon_q[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL oor_byte[%0d]: got %h expected %h", i, mon_q[i], exp[i]);
                end
            end
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_e_high();
        bit seen;
        write_byte(AW'(3), 8'h43);
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk); #1;
            if (lcd_e && lcd_rs) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL rst_e_wait: got no data strobe expected one"); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (lcd_e !== 1'b0)     begin n_bad++; $display("FAIL async_rst_e: got %b expected 0", lcd_e); end
        n_cmp++; if (lcd_rs !== 1'b0)    begin n_bad++; $display("FAIL async_rst_rs: got %b expected 0", lcd_rs); end
        n_cmp++; if (lcd_data !== 8'h00) begin n_bad++; $display("FAIL async_rst_data: got %h expected 00", lcd_data); end
        n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL async_rst_init_done: got %b expected 0", init_done); end
        repeat (2) @(negedge clk);
        test_init();
    endtask

    initial begin
        test_reset();
        test_init();
        test_single_write();
        test_mid_frame_write();
        test_out_of_range();
        test_reset_e_high();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
